ysyx_22040088_mcctrl: RTL and testbench
=======================================

Name: ysyx_22040088_mcctrl

Overview:
Multi-cycle control unit for the NPC core. It replaces the single-cycle combinational decoder with a sequencer that steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Each step handshakes with the IFU, LSU and the iterative mul/div unit. The block is parametrised in XLEN (RV32/RV64) and M-extension presence, tracks illegal instructions and ebreak, and counts retired instructions.

Parameters:
XLEN, 64, 32 or 64; when 32, OP-32/OP-IMM-32, ld, sd and lwu decode as illegal.
HAS_M, 1, when 0, any funct7=0000001 in OP/OP-32 is illegal.
CNT_W, 64, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  instruction register contents (stable from the cycle after ir_we)
ifu_req  out  1  fetch request, held until ifu_rvalid
ifu_rvalid  in  1  fetch data valid
ir_we  out  1  load instruction register (1-cycle pulse)
alu_start  out  1  start pulse to iterative mul/div unit
alu_done  in  1  mul/div result ready
lsu_req  out  1  memory request, held until lsu_done
lsu_done  in  1  memory access complete
mem_wen  out  1  store (valid with lsu_req)
mem_mask  out  4  one-hot size: 0001 dword, 0010 word, 0100 half, 1000 byte
sel_rfres  out  3  one-hot {unsigned-load, signed-load, alu}
rf_we  out  1  register-file write (WB only)
pc_we  out  1  PC update (WB only)
halt  out  1  sticky; ebreak reached or illegal instruction
inv  out  1  sticky; illegal instruction
state  out  3  current state encoding
retired  out  CNT_W  retired-instruction count

Behaviour:
- State encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- Reset (async, rst_n=0) sets state=IDLE, halt=0, inv=0 and retired=0. All request, pulse and write outputs are 0. mem_mask=0000 and sel_rfres=001.
- IDLE → IF after one cycle.
- IF: ifu_req=1. When ifu_rvalid=1, ir_we=1 in that same cycle and the next state is ID. ifu_rvalid in any other state is ignored.
- ID: one cycle of classification on inst[6:0].
  - Classes: LOAD, STORE, BRANCH, JAL, JALR, OP-IMM, OP-IMM-32, OP, OP-32, LUI, AUIPC, SYSTEM.
  - inst==0x00100073 (ebreak) → HALT with halt=1.
  - Any unknown opcode, reserved funct3/funct7, or an encoding made illegal by XLEN or HAS_M → HALT with inv=1 and halt=1.
  - Otherwise → EX. Leaving ID toward EX for mul/div/rem(w/u) asserts alu_start for exactly one cycle (the first EX cycle).
- EX:
  - mul/div: stay until alu_done=1. alu_done arriving in the same cycle as alu_start is legal and leaves EX that cycle.
  - Other classes: one cycle.
  - Then LOAD/STORE → MEM, all others → WB.
- MEM: lsu_req=1. mem_wen=1 for STORE. mem_mask is derived from funct3; it is stable for the whole MEM state. sel_rfres is valid from MEM through WB. When lsu_done=1 → WB.
- WB: one cycle. pc_we=1. rf_we=1 for every class except STORE and BRANCH. retired increments by 1 (wraps at 2^CNT_W). Next state is IF.
- HALT: absorbing. All request and write outputs stay 0. Only reset exits.
- Minimum latency per instruction: ALU ops take 4 cycles (IF with same-cycle rvalid, ID, EX, WB). Loads and stores take 5 plus memory wait.
- Reset mid-operation aborts any pending handshake immediately. The IFU and LSU must drop outstanding requests on reset.
- Outputs are Moore-style: decoded from state plus inst. They must not depend combinationally on ifu_rvalid, lsu_done or alu_done, with two exceptions: ir_we uses ifu_rvalid, and transitions use the handshake inputs.

Test Plan:
- Reset, then fetch 0x00500093 (addi x1,x0,5) with ifu_rvalid on the first IF cycle → state sequence 0,1,2,3,5,1. rf_we=1 and pc_we=1 for one cycle. retired=1.
- 0x0000B103 (ld x2,0(x1)) with XLEN=64 and lsu_done 3 cycles after the MEM state is entered → lsu_req held for 3 cycles, mem_wen=0, mem_mask=0001, sel_rfres=010 during WB, rf_we=1. With XLEN=32 → inv=1, halt=1, state=6.
- 0x0020B023 (sd x2,0(x1)) → MEM with mem_wen=1 and mask 0001. WB asserts pc_we=1 and rf_we=0.
- 0x022081BB (mulw) with HAS_M=1 and alu_done 10 cycles later → alu_start pulses once and EX lasts 10 cycles. With HAS_M=0 → inv=1.
- 0x00100073 (ebreak) → halt=1, inv=0. Further ifu_rvalid pulses cause no state change. retired is unchanged.
- Assert rst_n low mid-MEM with lsu_req=1 → state=0, lsu_req=0 and retired=0 immediately (asynchronously).

Source files
------------

// File: rtl/ysyx_22040088_mcctrl.sv
// Multi-cycle control sequencer for the NPC core: steps each instruction through
// IF/ID/EX/MEM/WB, handshakes with IFU, LSU and mul/div, and flags halt/illegal.
module ysyx_22040088_mcctrl #(
    parameter int XLEN  = 64,
    parameter bit HAS_M = 1'b1,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    output logic             ifu_req,
    input  logic             ifu_rvalid,
    output logic             ir_we,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             lsu_req,
    input  logic             lsu_done,
    output logic             mem_wen,
    output logic [3:0]       mem_mask,
    output logic [2:0]       sel_rfres,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             inv,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam bit          RV64        = (XLEN == 64);

    logic [2:0]       state_q, state_d;
    logic             halt_q, inv_q, ex_first_q;
    logic [CNT_W-1:0] retired_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       is_load, is_store, is_branch, is_muldiv, is_ebreak, illegal;
    logic       shamt_ok;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // RV64 shift immediates carry a 6-bit shamt, so only inst[31:26] is funct6.
    always_comb begin
        shamt_ok = 1'b0;
        if (RV64) begin
            shamt_ok = (funct3 == 3'b001) ? (inst[31:26] == 6'b000000)
                     : ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000));
        end else begin
            shamt_ok = (funct3 == 3'b001) ? (funct7 == 7'b0000000)
                     : ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end
    end

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_muldiv = 1'b0;
        is_ebreak = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                is_load = 1'b1;
                illegal = (funct3 == 3'b111) ||
                          (!RV64 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
            end
            OPC_STORE: begin
                is_store = 1'b1;
                illegal  = funct3[2] || (!RV64 && (funct3 == 3'b011));
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: illegal = 1'b0;
            OPC_JALR: illegal = (funct3 != 3'b000);
            OPC_OPIMM: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) illegal = !shamt_ok;
            end
            OPC_OPIMMW: begin
                if (!RV64) illegal = 1'b1;
                else if (funct3 == 3'b001) illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                else illegal = (funct3 != 3'b000);
            end
            OPC_OP: begin
                case (funct7)
                    7'b0000000: illegal = 1'b0;
                    7'b0100000: illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                    7'b0000001: begin
                        is_muldiv = HAS_M;
                        illegal   = !HAS_M;
                    end
                    default:    illegal = 1'b1;
                endcase
            end
            OPC_OPW: begin
                if (!RV64) illegal = 1'b1;
                else begin
                    case (funct7)
                        7'b0000000: illegal = !((funct3 == 3'b000) || (funct3 == 3'b001) ||
                                                (funct3 == 3'b101));
                        7'b0100000: illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                        7'b0000001: begin
                            is_muldiv = HAS_M && (funct3 != 3'b001) && (funct3 != 3'b010) &&
                                        (funct3 != 3'b011);
                            illegal   = !is_muldiv;
                        end
                        default:    illegal = 1'b1;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                if (inst == INST_EBREAK)     is_ebreak = 1'b1;
                else if (funct3 == 3'b000)   illegal   = (inst != INST_ECALL);
                else                         illegal   = (funct3 == 3'b100);
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            halt_q     <= 1'b0;
            inv_q      <= 1'b0;
            ex_first_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ex_first_q <= (state_q == S_ID);
            if (state_q == S_ID && (is_ebreak || illegal)) halt_q <= 1'b1;
            if (state_q == S_ID && illegal)                inv_q  <= 1'b1;
            if (state_q == S_WB) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   if (ifu_rvalid) state_d = S_ID;
            S_ID:   state_d = (is_ebreak || illegal) ? S_HALT : S_EX;
            S_EX: begin
                if (!is_muldiv || alu_done)
                    state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM:  if (lsu_done) state_d = S_WB;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Everything below is Moore except ir_we, which acknowledges the fetch in-cycle.
    always_comb begin
        ifu_req   = 1'b0;
        ir_we     = 1'b0;
        alu_start = 1'b0;
        lsu_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_mask  = 4'b0000;
        sel_rfres = 3'b001;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        case (state_q)
            S_IF: begin
                ifu_req = 1'b1;
                ir_we   = ifu_rvalid;
            end
            S_EX: alu_start = ex_first_q && is_muldiv;
            S_MEM: begin
                lsu_req = 1'b1;
                mem_wen = is_store;
                case (funct3[1:0])
                    2'b00:   mem_mask = 4'b1000;
                    2'b01:   mem_mask = 4'b0100;
                    2'b10:   mem_mask = 4'b0010;
                    default: mem_mask = 4'b0001;
                endcase
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = !(is_store || is_branch);
            end
            default: ;
        endcase
        if ((state_q == S_MEM || state_q == S_WB) && is_load)
            sel_rfres = funct3[2] ? 3'b100 : 3'b010;
    end

    assign state   = state_q;
    assign halt    = halt_q;
    assign inv     = inv_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_ysyx_22040088_mcctrl.sv
// Directed bench for ysyx_22040088_mcctrl: RV64+M main instance plus RV32 and
// no-M instances sharing the same stimulus to observe their illegal traps.
module tb_ysyx_22040088_mcctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        ifu_rvalid = 1'b0;
    logic        alu_done = 1'b0;
    logic        lsu_done = 1'b0;

    logic        ifu_req, ir_we, alu_start, lsu_req, mem_wen, rf_we, pc_we, halt, inv;
    logic [3:0]  mem_mask;
    logic [2:0]  sel_rfres, state;
    logic [63:0] retired;

    logic        a_ifu_req, a_ir_we, a_alu_start, a_lsu_req, a_mem_wen, a_rf_we, a_pc_we;
    logic        a_halt, a_inv;
    logic [3:0]  a_mem_mask;
    logic [2:0]  a_sel_rfres, a_state;
    logic [63:0] a_retired;

    logic        b_ifu_req, b_ir_we, b_alu_start, b_lsu_req, b_mem_wen, b_rf_we, b_pc_we;
    logic        b_halt, b_inv;
    logic [3:0]  b_mem_mask;
    logic [2:0]  b_sel_rfres, b_state;
    logic [63:0] b_retired;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    ysyx_22040088_mcctrl dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid),
        .ir_we(ir_we), .alu_start(alu_start), .alu_done(alu_done), .lsu_req(lsu_req),
        .lsu_done(lsu_done), .mem_wen(mem_wen), .mem_mask(mem_mask), .sel_rfres(sel_rfres),
        .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .inv(inv), .state(state), .retired(retired)
    );

    ysyx_22040088_mcctrl #(.XLEN(32)) dut_rv32 (
        .clk(clk), .rst_n(rst_n), .inst(inst), .ifu_req(a_ifu_req), .ifu_rvalid(ifu_rvalid),
        .ir_we(a_ir_we), .alu_start(a_alu_start), .alu_done(alu_done), .lsu_req(a_lsu_req),
        .lsu_done(lsu_done), .mem_wen(a_mem_wen), .mem_mask(a_mem_mask),
        .sel_rfres(a_sel_rfres), .rf_we(a_rf_we), .pc_we(a_pc_we), .halt(a_halt),
        .inv(a_inv), .state(a_state), .retired(a_retired)
    );

    ysyx_22040088_mcctrl #(.HAS_M(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .inst(inst), .ifu_req(b_ifu_req), .ifu_rvalid(ifu_rvalid),
        .ir_we(b_ir_we), .alu_start(b_alu_start), .alu_done(alu_done), .lsu_req(b_lsu_req),
        .lsu_done(lsu_done), .mem_wen(b_mem_wen), .mem_mask(b_mem_mask),
        .sel_rfres(b_sel_rfres), .rf_we(b_rf_we), .pc_we(b_pc_we), .halt(b_halt),
        .inv(b_inv), .state(b_state), .retired(b_retired)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag);
        logic [2:0] e;
        e = exp_q.pop_front();
        check(tag, {61'b0, state}, {61'b0, e});
    endtask

    // Waits (bounded) for IF, then returns the instruction with rvalid on that cycle.
    task automatic fetch(input logic [31:0] ins);
        int w;
        w = 0;
        while (state != 3'd1 && w < 20) begin
            tick();
            w++;
        end
        check("fetch_in_if", {61'b0, state}, 64'd1);
        inst = ins;
        ifu_rvalid = 1'b1;
        #1;
        check("ir_we", {63'b0, ir_we}, 64'd1);
        tick();
        ifu_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", {61'b0, state}, 64'd0);
        check("rst_flags", {58'b0, halt, inv, ifu_req, lsu_req, rf_we, pc_we}, 64'd0);
        check("rst_sel_mask", {57'b0, sel_rfres, mem_mask}, {57'b0, 3'b001, 4'b0000});
        check("rst_retired", retired, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, starts;
        logic mask_bad;

        do_reset();

        // addi x1,x0,5: IF ID EX WB IF
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        tick();
        expect_state("addi_if");
        check("addi_ifu_req", {63'b0, ifu_req}, 64'd1);
        inst = 32'h0050_0093;
        ifu_rvalid = 1'b1;
        #1;
        check("addi_ir_we", {63'b0, ir_we}, 64'd1);
        tick();
        ifu_rvalid = 1'b0;
        expect_state("addi_id");
        tick();
        expect_state("addi_ex");
        check("addi_no_start", {63'b0, alu_start}, 64'd0);
        tick();
        expect_state("addi_wb");
        check("addi_wb_we", {62'b0, rf_we, pc_we}, 64'd3);
        check("addi_ret_before", retired, 64'd0);
        tick();
        expect_state("addi_back_if");
        check("addi_retired", retired, 64'd1);
        check("addi_we_clear", {62'b0, rf_we, pc_we}, 64'd0);
        check("rv32_addi_retired", a_retired, 64'd1);

        // ld x2,0(x1): lsu_done in the third MEM cycle
        fetch(32'h0000_B103);
        check("ld_id", {61'b0, state}, 64'd2);
        tick();
        check("ld_ex", {61'b0, state}, 64'd3);
        check("rv32_ld_state", {61'b0, a_state}, 64'd6);
        check("rv32_ld_inv_halt", {62'b0, a_inv, a_halt}, 64'd3);
        tick();
        cnt = 0;
        mask_bad = 1'b0;
        for (int c = 0; c < 20 && state == 3'd4; c++) begin
            cnt += int'(lsu_req);
            if (mem_mask != 4'b0001 || mem_wen != 1'b0 || sel_rfres != 3'b010) mask_bad = 1'b1;
            if (c == 2) lsu_done = 1'b1;
            tick();
            lsu_done = 1'b0;
        end
        check("ld_lsu_req_cycles", cnt, 64'd3);
        check("ld_mem_outputs_bad", {63'b0, mask_bad}, 64'd0);
        check("ld_wb_state", {61'b0, state}, 64'd5);
        check("ld_wb_sel", {61'b0, sel_rfres}, 64'b010);
        check("ld_wb_we", {61'b0, rf_we, pc_we, lsu_req}, 64'b110);
        tick();
        check("ld_retired", retired, 64'd2);

        // sd x2,0(x1): single-cycle lsu_done
        fetch(32'h0020_B023);
        tick();
        tick();
        check("sd_mem_state", {61'b0, state}, 64'd4);
        check("sd_mem_out", {59'b0, mem_wen, mem_mask}, {59'b0, 1'b1, 4'b0001});
        check("sd_lsu_req", {63'b0, lsu_req}, 64'd1);
        lsu_done = 1'b1;
        tick();
        lsu_done = 1'b0;
        check("sd_wb_state", {61'b0, state}, 64'd5);
        check("sd_wb_we", {62'b0, pc_we, rf_we}, 64'b10);
        tick();
        check("sd_retired", retired, 64'd3);

        // mulw: alu_done in the tenth EX cycle
        fetch(32'h0220_81BB);
        check("nom_mulw_id", {61'b0, b_state}, 64'd2);
        tick();
        check("nom_mulw_halt", {61'b0, b_state}, 64'd6);
        check("nom_mulw_inv", {62'b0, b_inv, b_halt}, 64'd3);
        cnt = 0;
        starts = 0;
        for (int c = 0; c < 40 && state == 3'd3; c++) begin
            cnt++;
            starts += int'(alu_start);
            if (cnt == 10) alu_done = 1'b1;
            tick();
            alu_done = 1'b0;
        end
        check("mulw_ex_cycles", cnt, 64'd10);
        check("mulw_start_pulses", starts, 64'd1);
        check("mulw_wb", {61'b0, state}, 64'd5);
        tick();
        check("mulw_retired", retired, 64'd4);

        // ebreak: halt without inv, later fetch pulses ignored
        fetch(32'h0010_0073);
        tick();
        check("ebreak_state", {61'b0, state}, 64'd6);
        check("ebreak_halt_inv", {62'b0, halt, inv}, 64'b10);
        for (int i = 0; i < 3; i++) begin
            ifu_rvalid = 1'b1;
            #1;
            check("halt_ir_we", {62'b0, ir_we, ifu_req}, 64'd0);
            tick();
            ifu_rvalid = 1'b0;
        end
        check("halt_absorb", {61'b0, state}, 64'd6);
        check("halt_retired", retired, 64'd4);

        // reset in the middle of a lbu MEM phase
        do_reset();
        fetch(32'h0050_0093);
        tick();
        tick();
        tick();
        check("r_addi_retired", retired, 64'd1);
        fetch(32'h0000_C103);
        tick();
        tick();
        check("lbu_mem_state", {61'b0, state}, 64'd4);
        check("lbu_mem_out", {56'b0, lsu_req, sel_rfres, mem_mask},
              {56'b0, 1'b1, 3'b100, 4'b1000});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {61'b0, state}, 64'd0);
        check("mid_rst_lsu_req", {63'b0, lsu_req}, 64'd0);
        check("mid_rst_retired", retired, 64'd0);
        check("mid_rst_rv32", {61'b0, a_state}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_if", {61'b0, state}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
